// File: rtl/hdmi_tmds_encoder.sv
// Multi-channel TMDS encoder for an HDMI transmitter.
// Each channel does DVI 8b/10b video coding with running-disparity tracking. It also emits
// control tokens, video/data guard bands and TERC4 data-island symbols. All channels share
// one Mode. Latency is a fixed 3 clocks for every mode.
//
// Ports
//   Clk   pixel clock
//   RstB  asynchronous active-low reset
//   Mode  0=CTRL 1=VIDEO 2=VIDEO_GUARD 3=DATA_ISLAND 4=DATA_GUARD (5-7 behave as CTRL)
//   Din   video bytes, channel i at [8i+7:8i]
//   Ctrl  {C1,C0} per channel at [2i+1:2i]
//   Aux   TERC4 nibbles per channel at [4i+3:4i]
//   Dout  registered 10-bit symbols, channel i at [10i+9:10i], bit 0 sent first
module hdmi_tmds_encoder #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                   Clk,
  input  logic                   RstB,
  input  logic [2:0]             Mode,
  input  logic [8*NUM_CH-1:0]    Din,
  input  logic [2*NUM_CH-1:0]    Ctrl,
  input  logic [4*NUM_CH-1:0]    Aux,
  output logic [10*NUM_CH-1:0]   Dout
);

  localparam logic [2:0] ModeVideo      = 3'd1;
  localparam logic [2:0] ModeVideoGuard = 3'd2;
  localparam logic [2:0] ModeDataIsland = 3'd3;
  localparam logic [2:0] ModeDataGuard  = 3'd4;

  // Guard-band symbols: A on channels 0 and 2 (mod 3), B on channel 1.
  localparam logic [9:0] GuardA = 10'b1011001100;
  localparam logic [9:0] GuardB = 10'b0100110011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int b = 0; b < 8; b++) begin
      n = n + {3'b000, d[b]};
    end
    return n;
  endfunction

  // Transition-minimising stage: xnor chain when the byte is 1-heavy, xor chain otherwise.
  function automatic logic [8:0] qm_encode(input logic [7:0] d, input logic [3:0] n1);
    logic [8:0] q;
    logic       xnor_sel;
    xnor_sel = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0] = d[0];
    for (int b = 1; b < 8; b++) begin
      q[b] = xnor_sel ? ~(q[b-1] ^ d[b]) : (q[b-1] ^ d[b]);
    end
    q[8] = ~xnor_sel;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    unique case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] a);
    logic [9:0] t;
    unique case (a)
      4'h0:    t = 10'b1010011100;
      4'h1:    t = 10'b1001100011;
      4'h2:    t = 10'b1011100100;
      4'h3:    t = 10'b1011100010;
      4'h4:    t = 10'b0101110001;
      4'h5:    t = 10'b0100011110;
      4'h6:    t = 10'b0110001110;
      4'h7:    t = 10'b0100111100;
      4'h8:    t = 10'b1011001100;
      4'h9:    t = 10'b0100111001;
      4'hA:    t = 10'b0110011100;
      4'hB:    t = 10'b1011000110;
      4'hC:    t = 10'b1010001110;
      4'hD:    t = 10'b1001110001;
      4'hE:    t = 10'b0101100011;
      default: t = 10'b1011000011;
    endcase
    return t;
  endfunction

  // Mode is shared, so its delay line lives outside the per-channel logic.
  logic [2:0] mode_s1_q, mode_s2_q;

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
    end else begin
      mode_s1_q <= Mode;
      mode_s2_q <= mode_s1_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    localparam int unsigned Flavour = i % 3;

    logic [7:0]       din_s1_q;
    logic [3:0]       n1_d, n1_s1_q;
    logic [1:0]       ctrl_s1_q, ctrl_s2_q;
    logic [3:0]       aux_s1_q, aux_s2_q;
    logic [8:0]       qm_d, qm_s2_q;
    logic [3:0]       n1q_d, n1q_s2_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [9:0]       dout_d, dout_q;

    logic             q8, cnt_zero, cnt_neg;
    logic [CNT_W-1:0] n1_ext, diff;

    always_comb begin
      n1_d  = popcount8(Din[8*i +: 8]);
      qm_d  = qm_encode(din_s1_q, n1_s1_q);
      n1q_d = popcount8(qm_d[7:0]);
    end

    // Stage 3: symbol select plus disparity update. diff = n1q - n0q = 2*n1q - 8, computed
    // modulo 2^CNT_W so the sign bit of cnt_q carries the sign.
    always_comb begin
      q8       = qm_s2_q[8];
      n1_ext   = CNT_W'(n1q_s2_q);
      diff     = (n1_ext << 1) - CNT_W'(8);
      cnt_zero = (cnt_q == '0);
      cnt_neg  = cnt_q[CNT_W-1];
      dout_d   = ctrl_token(ctrl_s2_q);
      cnt_d    = '0;
      case (mode_s2_q)
        ModeVideo: begin
          if (cnt_zero || (n1q_s2_q == 4'd4)) begin
            dout_d = {~q8, q8, q8 ? qm_s2_q[7:0] : ~qm_s2_q[7:0]};
            cnt_d  = q8 ? (cnt_q + diff) : (cnt_q - diff);
          end else if ((!cnt_neg && (n1q_s2_q > 4'd4)) || (cnt_neg && (n1q_s2_q < 4'd4))) begin
            dout_d = {1'b1, q8, ~qm_s2_q[7:0]};
            cnt_d  = cnt_q + (q8 ? CNT_W'(2) : '0) - diff;
          end else begin
            dout_d = {1'b0, q8, qm_s2_q[7:0]};
            cnt_d  = cnt_q + diff - (q8 ? '0 : CNT_W'(2));
          end
        end
        ModeVideoGuard: dout_d = (Flavour == 1) ? GuardB : GuardA;
        ModeDataIsland: dout_d = terc4(aux_s2_q);
        ModeDataGuard:  dout_d = (Flavour == 0) ? terc4(aux_s2_q) : GuardB;
        default: ;
      endcase
    end

    always_ff @(posedge Clk or negedge RstB) begin
      if (!RstB) begin
        din_s1_q  <= '0;
        n1_s1_q   <= '0;
        ctrl_s1_q <= '0;
        ctrl_s2_q <= '0;
        aux_s1_q  <= '0;
        aux_s2_q  <= '0;
        qm_s2_q   <= '0;
        n1q_s2_q  <= '0;
        cnt_q     <= '0;
        dout_q    <= '0;
      end else begin
        din_s1_q  <= Din[8*i +: 8];
        n1_s1_q   <= n1_d;
        ctrl_s1_q <= Ctrl[2*i +: 2];
        ctrl_s2_q <= ctrl_s1_q;
        aux_s1_q  <= Aux[4*i +: 4];
        aux_s2_q  <= aux_s1_q;
        qm_s2_q   <= qm_d;
        n1q_s2_q  <= n1q_d;
        cnt_q     <= cnt_d;
        dout_q    <= dout_d;
      end
    end

    assign Dout[10*i +: 10] = dout_q;
  end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Directed bench for hdmi_tmds_encoder (3 channels), with a reference encoder for random video.
module tb_hdmi_tmds_encoder;

  localparam logic [9:0] Tok0   = 10'b1101010100;
  localparam logic [9:0] Tok1   = 10'b0010101011;
  localparam logic [9:0] Tok2   = 10'b0101010100;
  localparam logic [9:0] Tok3   = 10'b1010101011;
  localparam logic [9:0] GuardA = 10'b1011001100;
  localparam logic [9:0] GuardB = 10'b0100110011;

  logic        Clk = 1'b0;
  logic        RstB = 1'b0;
  logic [2:0]  Mode = '0;
  logic [23:0] Din = '0;
  logic [5:0]  Ctrl = '0;
  logic [11:0] Aux = '0;
  logic [29:0] Dout;

  int errors = 0;
  int checks = 0;

  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Expectations for symbols in flight, oldest first.
  logic [29:0] exp_q [$];
  bit          chk_q [$];
  bit          dec_q [$];
  logic [23:0] din_q [$];
  string       tag_q [$];

  int cnt_m [3];

  hdmi_tmds_encoder #(.NUM_CH(3), .CNT_W(5)) dut (
    .Clk  (Clk),
    .RstB (RstB),
    .Mode (Mode),
    .Din  (Din),
    .Ctrl (Ctrl),
    .Aux  (Aux),
    .Dout (Dout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q, o;
    q = s[9] ? ~s[7:0] : s[7:0];
    o[0] = q[0];
    for (int b = 1; b < 8; b++) o[b] = s[8] ? (q[b] ^ q[b-1]) : ~(q[b] ^ q[b-1]);
    return o;
  endfunction

  function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cin, output int cout);
    int         n1, n1q, n0q;
    logic       xn;
    logic [8:0] q;
    logic [9:0] s;
    n1 = $countones(d);
    xn = (n1 > 4) || ((n1 == 4) && !d[0]);
    q[0] = d[0];
    for (int b = 1; b < 8; b++) q[b] = xn ? ~(q[b-1] ^ d[b]) : (q[b-1] ^ d[b]);
    q[8] = ~xn;
    n1q = $countones(q[7:0]);
    n0q = 8 - n1q;
    if (cin == 0 || n1q == n0q) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cout = cin + (q[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
      s = {1'b1, q[8], ~q[7:0]};
      cout = cin + 2 * int'(q[8]) + n0q - n1q;
    end else begin
      s = {1'b0, q[8], q[7:0]};
      cout = cin + n1q - n0q - (q[8] ? 0 : 2);
    end
    return s;
  endfunction

  // One clock: check the symbol whose inputs went in three negedges ago, then drive new inputs.
  task automatic step(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                      input logic [11:0] a, input logic [29:0] e, input bit chk, input bit dc,
                      input string tag);
    logic [29:0] e0;
    logic [23:0] d0;
    bit          c0, dc0;
    string       t0;
    @(negedge Clk);
    if (exp_q.size() == 3) begin
      e0 = exp_q.pop_front();
      c0 = chk_q.pop_front();
      dc0 = dec_q.pop_front();
      d0 = din_q.pop_front();
      t0 = tag_q.pop_front();
      if (c0) check(t0, Dout, e0);
      if (dc0) check({t0, "_decode"}, {6'b0, dec(Dout[29:20]), dec(Dout[19:10]), dec(Dout[9:0])},
                     {6'b0, d0});
    end
    Mode = m;
    Din  = d;
    Ctrl = c;
    Aux  = a;
    exp_q.push_back(e);
    chk_q.push_back(chk);
    dec_q.push_back(dc);
    din_q.push_back(d);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    repeat (3) step(3'd0, '0, '0, '0, '0, 1'b0, 1'b0, "idle");
  endtask

  task automatic video_ref(input logic [23:0] d, input string tag);
    logic [29:0] e;
    int          nc;
    for (int ch = 0; ch < 3; ch++) begin
      e[10*ch +: 10] = ref_enc(d[8*ch +: 8], cnt_m[ch], nc);
      cnt_m[ch] = nc;
    end
    step(3'd1, d, '0, '0, e, 1'b1, 1'b1, tag);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    chk_q.delete();
    dec_q.delete();
    din_q.delete();
    tag_q.delete();
  endtask

  initial begin
    // Reset state and first symbol after release.
    #12;
    check("reset_dout", Dout, '0);
    @(negedge Clk);
    RstB = 1'b1;
    @(posedge Clk);
    #1;
    check("post_reset_tok0", Dout, {3{Tok0}});

    // Video zeros from cnt=0: disparity walks -8, +2, -6, then 0xFF brings it back to 0.
    step(3'd1, 24'h000000, '0, '0, {3{10'b0100000000}}, 1'b1, 1'b1, "vid00_a");
    step(3'd1, 24'h000000, '0, '0, {3{10'b1111111111}}, 1'b1, 1'b1, "vid00_b");
    step(3'd1, 24'h000000, '0, '0, {3{10'b0100000000}}, 1'b1, 1'b1, "vid00_c");
    step(3'd1, 24'hFFFFFF, '0, '0, {3{10'b0011111111}}, 1'b1, 1'b1, "vidFF");
    step(3'd1, 24'h000000, '0, '0, {3{10'b0100000000}}, 1'b1, 1'b1, "vid00_d");

    // Control tokens, including mode 7 treated as CTRL.
    step(3'd0, '0, {3{2'b00}}, '0, {3{Tok0}}, 1'b1, 1'b0, "ctrl00");
    step(3'd0, '0, {3{2'b01}}, '0, {3{Tok1}}, 1'b1, 1'b0, "ctrl01");
    step(3'd0, '0, {3{2'b10}}, '0, {3{Tok2}}, 1'b1, 1'b0, "ctrl10");
    step(3'd0, '0, {3{2'b11}}, '0, {3{Tok3}}, 1'b1, 1'b0, "ctrl11");
    step(3'd7, '0, {3{2'b01}}, '0, {3{Tok1}}, 1'b1, 1'b0, "mode7_ctrl");
    step(3'd0, '0, {2'b10, 2'b01, 2'b00}, '0, {Tok2, Tok1, Tok0}, 1'b1, 1'b0, "ctrl_mixed");

    // Re-entering video after cnt was left at -8 must start from cnt=0.
    step(3'd1, 24'h000000, '0, '0, {3{10'b0100000000}}, 1'b1, 1'b1, "reenter_a");
    step(3'd0, '0, '0, '0, {3{Tok0}}, 1'b1, 1'b0, "reenter_ctrl");
    step(3'd1, 24'h000000, '0, '0, {3{10'b0100000000}}, 1'b1, 1'b1, "reenter_b");

    // Video guard band.
    step(3'd2, '0, '0, '0, {GuardA, GuardB, GuardA}, 1'b1, 1'b0, "vguard_a");
    step(3'd2, '0, '0, '0, {GuardA, GuardB, GuardA}, 1'b1, 1'b0, "vguard_b");

    // Data island sweep of all TERC4 codes; channels get different nibbles.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] a0, a1, a2;
      a0 = 4'(n);
      a1 = 4'(n + 5);
      a2 = 4'(15 - n);
      step(3'd3, '0, '0, {a2, a1, a0}, {terc4_tab[a2], terc4_tab[a1], terc4_tab[a0]},
           1'b1, 1'b0, "terc4");
    end

    // Data guard band: ch0 TERC4, others fixed.
    step(3'd4, '0, '0, {4'h5, 4'h5, 4'hC}, {GuardB, GuardB, 10'b1010001110}, 1'b1, 1'b0,
         "dguard");
    step(3'd1, 24'h000000, '0, '0, {3{10'b0100000000}}, 1'b1, 1'b1, "after_dguard");
    drain();

    // Random video against the reference encoder.
    cnt_m = '{0, 0, 0};
    for (int k = 0; k < 300; k++) video_ref(24'($urandom), "rnd_video");

    // Asynchronous reset mid-burst: cleared between edges, tokens afterwards.
    @(posedge Clk);
    #2;
    RstB = 1'b0;
    #1;
    check("midburst_reset", Dout, '0);
    clear_queues();
    Mode = '0;
    Din  = '0;
    Ctrl = '0;
    Aux  = '0;
    @(negedge Clk);
    RstB = 1'b1;
    @(posedge Clk);
    #1;
    check("midburst_tok0", Dout, {3{Tok0}});
    cnt_m = '{0, 0, 0};
    for (int k = 0; k < 300; k++) video_ref(24'($urandom), "rnd_video2");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
